vedic_mac_acc: RTL and testbench



---
 rtl/vedic_pkg.sv | 13 +
 rtl/Vedic16x16_Top.sv | 24 ++
 rtl/vedic_mac_acc.sv | 159 +++++++++++++++
 tb/tb_vedic_mac_acc.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vedic_pkg.sv
// Shared definitions for the Vedic multiplier datapath and the MAC accumulator
// built on top of it.
package vedic_pkg;

  localparam int OP_W   = 16;
  localparam int PROD_W = 32;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

endpackage : vedic_pkg

// File: rtl/Vedic16x16_Top.sv
// Combinational 16x16 unsigned multiplier using the Urdhva-Tiryagbhyam
// (vertical and crosswise) split into four 8x8 partial products.
module Vedic16x16_Top (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] Q
);

  logic [15:0] ll_s;
  logic [15:0] lh_s;
  logic [15:0] hl_s;
  logic [15:0] hh_s;
  logic [16:0] mid_s;

  assign ll_s  = {8'd0, a[7:0]}  * {8'd0, b[7:0]};
  assign lh_s  = {8'd0, a[7:0]}  * {8'd0, b[15:8]};
  assign hl_s  = {8'd0, a[15:8]} * {8'd0, b[7:0]};
  assign hh_s  = {8'd0, a[15:8]} * {8'd0, b[15:8]};

  // Crosswise terms are summed once, then placed at the middle byte.
  assign mid_s = {1'b0, lh_s} + {1'b0, hl_s};
  assign Q     = {hh_s, ll_s} + {7'd0, mid_s, 8'd0};

endmodule : Vedic16x16_Top

// File: rtl/vedic_mac_acc.sv
// Pipelined unsigned multiply-accumulate over in_last-delimited frames with a
// one-entry valid/ready result register and a single global advance enable.
module vedic_mac_acc
  import vedic_pkg::*;
#(
  parameter int ACC_W = 40,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_a,
  input  logic [OP_W-1:0]  in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  out_state_e          state_r;
  out_state_e          state_nxt_s;
  logic                en_s;
  logic                complete_s;

  logic [OP_W-1:0]     a_r;
  logic [OP_W-1:0]     b_r;
  logic                v1_r;
  logic                last1_r;

  logic [PROD_W-1:0]   q_s;
  logic [PROD_W-1:0]   p_r;
  logic                v2_r;
  logic                last2_r;

  logic [ACC_W-1:0]    acc_r;
  logic [CNT_W-1:0]    cnt_r;
  logic                ovf_r;
  logic [ACC_W:0]      sum_s;
  logic [CNT_W-1:0]    cnt_n_s;
  logic                ovf_n_s;

  // The whole pipeline advances together; a held result stalls everything.
  assign en_s       = (state_r == OUT_EMPTY) || out_ready;
  assign in_ready   = en_s;
  assign out_valid  = (state_r == OUT_FULL);
  assign complete_s = v2_r && last2_r && en_s;

  assign sum_s   = {1'b0, acc_r} + {{(ACC_W + 1 - PROD_W){1'b0}}, p_r};
  assign cnt_n_s = (cnt_r == {CNT_W{1'b1}}) ? cnt_r : (cnt_r + CNT_W'(1));
  assign ovf_n_s = ovf_r | sum_s[ACC_W];

  Vedic16x16_Top u_mul (
    .a (a_r),
    .b (b_r),
    .Q (q_s)
  );

  // Operand register stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r     <= {OP_W{1'b0}};
      b_r     <= {OP_W{1'b0}};
      v1_r    <= 1'b0;
      last1_r <= 1'b0;
    end else if (en_s) begin
      if (in_valid) begin
        a_r     <= in_a;
        b_r     <= in_b;
        v1_r    <= 1'b1;
        last1_r <= in_last;
      end else begin
        v1_r    <= 1'b0;
        last1_r <= 1'b0;
      end
    end
  end

  // Product register stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_r     <= {PROD_W{1'b0}};
      v2_r    <= 1'b0;
      last2_r <= 1'b0;
    end else if (en_s) begin
      p_r     <= q_s;
      v2_r    <= v1_r;
      last2_r <= last1_r;
    end
  end

  // Running frame accumulator; cleared when a frame is handed to the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= {ACC_W{1'b0}};
      cnt_r <= {CNT_W{1'b0}};
      ovf_r <= 1'b0;
    end else if (v2_r && en_s) begin
      if (last2_r) begin
        acc_r <= {ACC_W{1'b0}};
        cnt_r <= {CNT_W{1'b0}};
        ovf_r <= 1'b0;
      end else begin
        acc_r <= sum_s[ACC_W-1:0];
        cnt_r <= cnt_n_s;
        ovf_r <= ovf_n_s;
      end
    end
  end

  // Result register, loaded only when a frame completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_acc   <= {ACC_W{1'b0}};
      out_count <= {CNT_W{1'b0}};
      out_ovf   <= 1'b0;
    end else if (complete_s) begin
      out_acc   <= sum_s[ACC_W-1:0];
      out_count <= cnt_n_s;
      out_ovf   <= ovf_n_s;
    end
  end

  // Output FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= OUT_EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Output FSM next state; a completion during a pop keeps the slot full.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      OUT_EMPTY: begin
        if (complete_s) begin
          state_nxt_s = OUT_FULL;
        end else begin
          state_nxt_s = OUT_EMPTY;
        end
      end
      OUT_FULL: begin
        if (out_ready && !complete_s) begin
          state_nxt_s = OUT_EMPTY;
        end else begin
          state_nxt_s = OUT_FULL;
        end
      end
      default: begin
        state_nxt_s = OUT_EMPTY;
      end
    endcase
  end

endmodule : vedic_mac_acc

// File: tb/tb_vedic_mac_acc.sv
// Self-checking bench: two instances (ACC_W=40 and ACC_W=32) share stimulus;
// a frame-level sum model predicts every result, plus literal spot checks.
module tb_vedic_mac_acc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] in_a = 16'd0;
  logic [15:0] in_b = 16'd0;

  logic        in_ready40, out_valid40, out_ovf40;
  logic [39:0] out_acc40;
  logic [7:0]  out_count40;
  logic        in_ready32, out_valid32, out_ovf32;
  logic [31:0] out_acc32;
  logic [7:0]  out_count32;

  int checks = 0;
  int errors = 0;
  int results = 0;

  logic [39:0] r_acc40;
  logic [31:0] r_acc32;
  logic [7:0]  r_cnt;
  logic        r_ovf40, r_ovf32;

  typedef struct {
    longint unsigned sum;
    int              cnt;
  } frame_t;

  frame_t          exp_q[$];
  longint unsigned m_sum;
  int              m_cnt;

  always #5 clk = ~clk;

  vedic_mac_acc #(.ACC_W(40), .CNT_W(8)) dut40 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready40),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid40),
    .out_ready(out_ready), .out_acc(out_acc40), .out_count(out_count40),
    .out_ovf(out_ovf40)
  );

  vedic_mac_acc #(.ACC_W(32), .CNT_W(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid32),
    .out_ready(out_ready), .out_acc(out_acc32), .out_count(out_count32),
    .out_ovf(out_ovf32)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor and scoreboard: samples on the falling edge, away from updates.
  initial begin
    frame_t      f;
    logic        stall_prev;
    logic [39:0] h_acc;
    logic [7:0]  h_cnt;
    logic        h_ovf;
    stall_prev = 1'b0;
    h_acc = 40'd0;
    h_cnt = 8'd0;
    h_ovf = 1'b0;
    m_sum = 64'd0;
    m_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_sum = 64'd0;
        m_cnt = 0;
        exp_q.delete();
        stall_prev = 1'b0;
      end else begin
        check("in_ready_rule", {63'd0, in_ready40}, {63'd0, (!out_valid40 || out_ready)});
        check("twin_handshake", {62'd0, in_ready32, out_valid32}, {62'd0, in_ready40, out_valid40});
        if (stall_prev) begin
          check("stall_stable", {out_acc40, out_count40, out_ovf40}, {h_acc, h_cnt, h_ovf});
        end
        if (in_valid && in_ready40) begin
          m_sum += longint'(in_a) * longint'(in_b);
          m_cnt++;
          if (in_last) begin
            f.sum = m_sum;
            f.cnt = m_cnt;
            exp_q.push_back(f);
            m_sum = 64'd0;
            m_cnt = 0;
          end
        end
        if (out_valid40) begin
          if (exp_q.size() == 0) begin
            check("spurious_valid", 64'd1, 64'd0);
          end else if (out_ready) begin
            f = exp_q.pop_front();
            check("acc40", out_acc40, f.sum % (64'd1 << 40));
            check("ovf40", out_ovf40, (f.sum >> 40) != 0);
            check("acc32", out_acc32, f.sum % (64'd1 << 32));
            check("ovf32", out_ovf32, (f.sum >> 32) != 0);
            check("count", out_count40, (f.cnt > 255) ? 255 : f.cnt);
            check("count32", out_count32, (f.cnt > 255) ? 255 : f.cnt);
            r_acc40 = out_acc40;
            r_acc32 = out_acc32;
            r_cnt   = out_count40;
            r_ovf40 = out_ovf40;
            r_ovf32 = out_ovf32;
            results++;
          end
        end
        stall_prev = out_valid40 && !out_ready;
        h_acc = out_acc40;
        h_cnt = out_count40;
        h_ovf = out_ovf40;
      end
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic last);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready40) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    check("send_timeout", 64'd1, 64'd0);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_result(input int n0);
    for (int i = 0; i < 60; i++) begin
      if (results > n0) return;
      @(posedge clk);
      #2;
    end
    check("result_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    int n;
    idle(3);
    check("rst_in_ready", {63'd0, in_ready40}, 64'd1);
    check("rst_out", {out_valid40, out_acc40, out_count40, out_ovf40}, 64'd0);
    rst_n = 1'b1;
    idle(1);

    // Single sample: valid exactly 3 cycles after presentation.
    n = results;
    send(16'd3, 16'd5, 1'b1);
    idle(1);
    check("lat_k1", {63'd0, out_valid40}, 64'd0);
    idle(1);
    check("lat_k2", {63'd0, out_valid40}, 64'd1);
    wait_result(n);
    check("lit_3x5", r_acc40, 64'd15);
    check("lit_3x5_cnt", r_cnt, 64'd1);
    check("lit_3x5_ovf", r_ovf40, 64'd0);

    // Four maximal products.
    n = results;
    for (int i = 0; i < 4; i++) send(16'hFFFF, 16'hFFFF, i == 3);
    wait_result(n);
    check("lit_4max", r_acc40, 64'h3_FFF8_0004);
    check("lit_4max_cnt", r_cnt, 64'd4);
    check("lit_4max_ovf", r_ovf40, 64'd0);

    // Narrow accumulator overflow, then a clean frame.
    n = results;
    send(16'hFFFF, 16'hFFFF, 1'b0);
    send(16'hFFFF, 16'hFFFF, 1'b1);
    wait_result(n);
    check("lit_ovf32_acc", r_acc32, 64'hFFFC_0002);
    check("lit_ovf32_flag", r_ovf32, 64'd1);
    send(16'd1, 16'd1, 1'b1);
    wait_result(n + 1);
    check("lit_clean_acc", r_acc32, 64'd1);
    check("lit_clean_ovf", r_ovf32, 64'd0);

    // Back-to-back singles, then a frame with bubbles.
    n = results;
    send(16'd100, 16'd200, 1'b1);
    send(16'hFFFF, 16'd1, 1'b1);
    send(16'd0, 16'd5, 1'b1);
    send(16'd10, 16'd10, 1'b0);
    idle(2);
    send(16'd4, 16'd5, 1'b0);
    idle(1);
    send(16'd1, 16'd2, 1'b1);
    wait_result(n + 3);
    check("lit_bubble", r_acc40, 64'd122);
    check("lit_bubble_cnt", r_cnt, 64'd3);

    // Stall: result held for 5 cycles while the next pair waits.
    out_ready = 1'b0;
    n = results;
    send(16'd9, 16'd9, 1'b1);
    for (int i = 0; i < 10 && !out_valid40; i++) idle(1);
    in_valid = 1'b1;
    in_a     = 16'd2;
    in_b     = 16'd2;
    in_last  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      idle(1);
      check("stall_in_ready", {63'd0, in_ready40}, 64'd0);
      check("stall_held", out_acc40, 64'd81);
    end
    out_ready = 1'b1;
    send(16'd2, 16'd2, 1'b0);
    send(16'd3, 16'd3, 1'b1);
    wait_result(n);
    check("lit_stalled", r_acc40, 64'd81);
    wait_result(n + 1);
    check("lit_after_stall", r_acc40, 64'd13);
    check("lit_after_stall_cnt", r_cnt, 64'd2);

    // Count saturation.
    n = results;
    for (int i = 0; i < 300; i++) send(16'd1, 16'd1, i == 299);
    wait_result(n);
    check("lit_sat_acc", r_acc40, 64'd300);
    check("lit_sat_cnt", r_cnt, 64'd255);

    // Reset mid-frame discards the partial frame.
    n = results;
    send(16'd5, 16'd5, 1'b0);
    send(16'd6, 16'd6, 1'b0);
    idle(1);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    check("midrst_out", {out_valid40, out_acc40, out_count40}, 64'd0);
    idle(5);
    check("midrst_no_result", results, n);
    send(16'd7, 16'd6, 1'b1);
    wait_result(n);
    check("lit_7x6", r_acc40, 64'd42);
    check("lit_7x6_cnt", r_cnt, 64'd1);

    idle(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_vedic_mac_acc
